wb_gpio_v2: RTL and testbench



---
 rtl/wb_gpio_v2.sv | 206 ++++++++++++++++++++
 tb/tb_wb_gpio_v2.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_v2.sv
// wb_gpio_v2: pipelined Wishbone B4 GPIO peripheral with per-pin direction,
// atomic set/clear/toggle aliases and per-pin edge/level interrupts.
// Optional macro WB_GPIO_DEBOUNCE_EN adds a per-pin debounce filter with DBEN enables.
module wb_gpio_v2 #(
    parameter logic [31:0] WB_BASE_ADDRESS = 32'h4001_0000,
    parameter logic [31:0] IP_VERSION      = 32'h0002_0000,
    parameter logic [31:0] IP_DEVICE_ID    = 32'h000A_0000,
    parameter int          GPIO_WIDTH      = 32,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                  i_wb_clk,
    input  logic                  i_wb_rst_n,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [31:0]           i_wb_addr,
    input  logic [31:0]           i_wb_dat,
    input  logic [3:0]            i_wb_sel,
    output logic [31:0]           o_wb_dat,
    output logic                  o_wb_stall,
    output logic                  o_wb_ack,
    inout  wire  [GPIO_WIDTH-1:0] io_gpio,
    output logic                  o_interrupt
);

    // Word offsets (byte offset >> 2) inside the 64-byte window
    localparam logic [3:0] OFF_VERSION = 4'h0;
    localparam logic [3:0] OFF_DEVID   = 4'h1;
    localparam logic [3:0] OFF_GIE     = 4'h2;
    localparam logic [3:0] OFF_IER     = 4'h3;
    localparam logic [3:0] OFF_ISR     = 4'h4;
    localparam logic [3:0] OFF_DIR     = 4'h8;
    localparam logic [3:0] OFF_DATA    = 4'h9;
    localparam logic [3:0] OFF_SET     = 4'hA;
    localparam logic [3:0] OFF_CLR     = 4'hB;
    localparam logic [3:0] OFF_TGL     = 4'hC;
    localparam logic [3:0] OFF_IMODE0  = 4'hD;
    localparam logic [3:0] OFF_IMODE1  = 4'hE;
`ifdef WB_GPIO_DEBOUNCE_EN
    localparam logic [3:0] OFF_DBEN    = 4'hF;
`endif

    typedef logic [GPIO_WIDTH-1:0] pins_t;

    function automatic logic [31:0] zext(input pins_t v);
        zext = '0;
        zext[GPIO_WIDTH-1:0] = v;
    endfunction

    logic                  accept;
    logic                  wr_en;
    logic [3:0]            offset;
    logic [31:0]           byte_mask;
    pins_t                 wmask;
    pins_t                 wbits;
    logic                  ack_q;
    logic                  gie_q;
    pins_t                 ier_q, isr_q, dir_q, out_q, imode0_q, imode1_q;
    pins_t                 sync_q [SYNC_STAGES];
    pins_t                 sync_out;
    pins_t                 filt;
    pins_t                 prev_q;
    pins_t                 event_vec;
    pins_t                 isr_clr;
    logic [31:0]           rdata;
    logic                  unused_bits;

    assign offset    = i_wb_addr[5:2];
    assign accept    = i_wb_cyc && i_wb_stb && (i_wb_addr[31:6] == WB_BASE_ADDRESS[31:6]);
    assign wr_en     = accept && i_wb_we;
    assign byte_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign wmask     = byte_mask[GPIO_WIDTH-1:0];
    assign wbits     = i_wb_dat[GPIO_WIDTH-1:0] & wmask;
    assign o_wb_stall  = 1'b0;
    assign o_wb_ack    = ack_q && i_wb_cyc;
    assign unused_bits = ^{i_wb_addr[1:0], i_wb_dat, i_wb_sel};

    // Each pin is released when configured as input, otherwise driven from OUT
    for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_pad
        assign io_gpio[g] = dir_q[g] ? 1'bz : out_q[g];
    end

    // Multi-stage synchroniser bringing the pads into the bus clock domain
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= io_gpio;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef WB_GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] db_cnt [GPIO_WIDTH];
    pins_t            db_val;
    pins_t            dben_q;

    // Debounce: accept a new level only after it persisted DEBOUNCE_CYCLES cycles
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            db_val <= '0;
            for (int i = 0; i < GPIO_WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                if (!dben_q[i] || (sync_out[i] == db_val[i])) begin
                    db_cnt[i] <= '0;
                    db_val[i] <= sync_out[i];
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    db_val[i] <= sync_out[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign filt = (dben_q & db_val) | (~dben_q & sync_out);
`else
    assign filt = sync_out;
`endif

    // Per-pin event selection from the filtered value and its previous sample
    always_comb begin
        event_vec = (~imode1_q & ~imode0_q & filt & ~prev_q)
                  | (~imode1_q &  imode0_q & ~filt & prev_q)
                  | ( imode1_q & ~imode0_q & (filt ^ prev_q))
                  | ( imode1_q &  imode0_q & filt);
        isr_clr   = (wr_en && (offset == OFF_ISR)) ? wbits : '0;
    end

    // Register file, bus-side write effects and interrupt status tracking
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            gie_q    <= 1'b0;
            ier_q    <= '0;
            isr_q    <= '0;
            dir_q    <= '1;
            out_q    <= '0;
            imode0_q <= '0;
            imode1_q <= '0;
            prev_q   <= '0;
`ifdef WB_GPIO_DEBOUNCE_EN
            dben_q   <= '0;
`endif
        end else begin
            prev_q <= filt;
            isr_q  <= (isr_q & ~isr_clr) | (event_vec & ier_q);
            if (wr_en) begin
                case (offset)
                    OFF_GIE:    if (i_wb_sel[3]) gie_q <= i_wb_dat[31];
                    OFF_IER:    ier_q    <= (ier_q & ~wmask) | wbits;
                    OFF_DIR:    dir_q    <= (dir_q & ~wmask) | wbits;
                    OFF_DATA:   out_q    <= (out_q & ~wmask) | wbits;
                    OFF_SET:    out_q    <= out_q | wbits;
                    OFF_CLR:    out_q    <= out_q & ~wbits;
                    OFF_TGL:    out_q    <= out_q ^ wbits;
                    OFF_IMODE0: imode0_q <= (imode0_q & ~wmask) | wbits;
                    OFF_IMODE1: imode1_q <= (imode1_q & ~wmask) | wbits;
`ifdef WB_GPIO_DEBOUNCE_EN
                    OFF_DBEN:   dben_q   <= (dben_q & ~wmask) | wbits;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Read data multiplexer
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_VERSION: rdata = IP_VERSION;
            OFF_DEVID:   rdata = IP_DEVICE_ID;
            OFF_GIE:     rdata = {gie_q, 31'd0};
            OFF_IER:     rdata = zext(ier_q);
            OFF_ISR:     rdata = zext(isr_q);
            OFF_DIR:     rdata = zext(dir_q);
            OFF_DATA:    rdata = zext(filt);
            OFF_IMODE0:  rdata = zext(imode0_q);
            OFF_IMODE1:  rdata = zext(imode1_q);
`ifdef WB_GPIO_DEBOUNCE_EN
            OFF_DBEN:    rdata = zext(dben_q);
`endif
            default:     rdata = '0;
        endcase
    end

    // Bus response: single-cycle ack with registered read data, plus the interrupt line
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            ack_q       <= 1'b0;
            o_wb_dat    <= '0;
            o_interrupt <= 1'b0;
        end else begin
            ack_q       <= accept;
            o_wb_dat    <= (accept && !i_wb_we) ? rdata : '0;
            o_interrupt <= gie_q && |(isr_q & ier_q);
        end
    end

endmodule

// File: tb/tb_wb_gpio_v2.sv
// Scoreboard testbench for wb_gpio_v2: a 32-pin instance and an 8-pin instance
// share one Wishbone master at different base addresses.
module tb_wb_gpio_v2;

    localparam logic [31:0] BASE_A = 32'h4001_0000;
    localparam logic [31:0] BASE_B = 32'h4002_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] addr, wdat;
    logic [3:0]  sel;
    logic [31:0] datA, datB;
    logic        stallA, stallB, ackA, ackB, irqA, irqB;
    wire  [31:0] padA;
    wire  [7:0]  padB;
    logic [31:0] padDrv, padEn;

    logic [31:0] expQ[$];
    bit          readQ[$];
    bit          dutBQ[$];
    string       nameQ[$];
    int          passCount = 0;
    int          checkCount = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 32; g++) begin : g_tbPad
        assign padA[g] = padEn[g] ? padDrv[g] : 1'bz;
    end

    wb_gpio_v2 #(.WB_BASE_ADDRESS(BASE_A), .GPIO_WIDTH(32)) dutA (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_dat(wdat), .i_wb_sel(sel),
        .o_wb_dat(datA), .o_wb_stall(stallA), .o_wb_ack(ackA),
        .io_gpio(padA), .o_interrupt(irqA)
    );

    wb_gpio_v2 #(.WB_BASE_ADDRESS(BASE_B), .GPIO_WIDTH(8)) dutB (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_dat(wdat), .i_wb_sel(sel),
        .o_wb_dat(datB), .o_wb_stall(stallB), .o_wb_ack(ackB),
        .io_gpio(padB), .o_interrupt(irqB)
    );

    // Monitor: pops the scoreboard on every ack and compares read data
    initial begin
        logic [31:0] e, got;
        bit          r, b;
        string       n;
        forever begin
            @(negedge clk);
            #1;
            if (ackA || ackB) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_ack: ackA=%0d ackB=%0d, required no ack", ackA, ackB);
                end else begin
                    e = expQ.pop_front();
                    r = readQ.pop_front();
                    b = dutBQ.pop_front();
                    n = nameQ.pop_front();
                    got = ackB ? datB : datA;
                    if (r) begin
                        checkCount++;
                        if ((b == ackB) && (got == e)) passCount++;
                        else $display("[TB] FAIL %s: got %h (ackB=%0d), required %h (ackB=%0d)", n, got, ackB, e, b);
                    end else if (b != ackB) begin
                        checkCount++;
                        $display("[TB] FAIL %s: write acked by wrong instance ackB=%0d, required %0d", n, ackB, b);
                    end
                end
            end
        end
    end

    // Immediate comparison for pads, interrupt and reset-time outputs
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    endtask

    // One Wishbone access; in-window accesses push their expected response first
    task automatic applyStimulus(input logic weI, input logic [31:0] addrI, input logic [31:0] dataI,
                                 input logic [3:0] selI, input logic [31:0] expI, input string nameI,
                                 input bit abandon);
        if (!abandon && ((addrI[31:6] == BASE_A[31:6]) || (addrI[31:6] == BASE_B[31:6]))) begin
            expQ.push_back(expI);
            readQ.push_back(!weI);
            dutBQ.push_back(addrI[31:6] == BASE_B[31:6]);
            nameQ.push_back(nameI);
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = weI; addr = addrI; wdat = dataI; sel = selI;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
        if (abandon) cyc = 1'b0;
        @(negedge clk);
        cyc = 1'b0;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, 4'hF, 32'h0, "write", 1'b0);
    endtask

    task automatic busRead(input logic [31:0] a, input logic [31:0] e, input string n);
        applyStimulus(1'b0, a, 32'h0, 4'hF, e, n, 1'b0);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cyc = 0; stb = 0; we = 0; addr = '0; wdat = '0; sel = '0;
        padDrv = 32'h1234_5678; padEn = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        waitCycles(3);
        checkOutput("reset_ack", {31'd0, ackA}, 32'h0);
        checkOutput("reset_dat", datA, 32'h0);
        checkOutput("reset_irq", {31'd0, irqA}, 32'h0);
        checkOutput("stall", {30'd0, stallA, stallB}, 32'h0);
        rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] reset readback");
        busRead(BASE_A + 32'h00, 32'h0002_0000, "version");
        busRead(BASE_A + 32'h04, 32'h000A_0000, "device_id");
        busRead(BASE_A + 32'h20, 32'hFFFF_FFFF, "dir_reset");
        busRead(BASE_A + 32'h24, 32'h1234_5678, "data_pad");
        busRead(BASE_A + 32'h10, 32'h0000_0000, "isr_reset");
        busRead(BASE_A + 32'h08, 32'h0000_0000, "gie_reset");

        $display("[TB] output path and aliases");
        padEn = 32'h0;
        busWrite(BASE_A + 32'h20, 32'h0000_0000);
        busWrite(BASE_A + 32'h24, 32'hA5A5_A5A5);
        busWrite(BASE_A + 32'h28, 32'h0000_000F);
        busWrite(BASE_A + 32'h2C, 32'hA000_0000);
        busWrite(BASE_A + 32'h30, 32'hFFFF_0000);
        checkOutput("pad_alias", padA, 32'hFA5A_A5AF);
        waitCycles(3);
        busRead(BASE_A + 32'h24, 32'hFA5A_A5AF, "data_readback");
        applyStimulus(1'b1, BASE_A + 32'h28, 32'h0000_0200, 4'hF, 32'h0, "abandoned_set", 1'b1);
        checkOutput("pad_abandoned_write", padA, 32'hFA5A_A7AF);
        applyStimulus(1'b1, BASE_A + 32'h24, 32'h1122_3344, 4'b0101, 32'h0, "write_sel", 1'b0);
        checkOutput("pad_byte_lanes", padA, 32'hFA22_A744);

        $display("[TB] rising-edge interrupt");
        busWrite(BASE_A + 32'h20, 32'hFFFF_FFFF);
        padDrv = 32'h0; padEn = 32'hFFFF_FFFF;
        waitCycles(4);
        busWrite(BASE_A + 32'h0C, 32'hFFFF_FFFF);
        busWrite(BASE_A + 32'h08, 32'hFFFF_FFFF);
        waitCycles(2);
        busRead(BASE_A + 32'h08, 32'h8000_0000, "gie_bit31_only");
        busRead(BASE_A + 32'h10, 32'h0000_0000, "isr_quiet");
        checkOutput("irq_quiet", {31'd0, irqA}, 32'h0);
        padDrv = 32'h0000_0001;
        waitCycles(5);
        checkOutput("irq_rise", {31'd0, irqA}, 32'h1);
        busRead(BASE_A + 32'h10, 32'h0000_0001, "isr_rise");
        busWrite(BASE_A + 32'h10, 32'hFFFF_FFFF);
        checkOutput("irq_cleared", {31'd0, irqA}, 32'h0);
        waitCycles(2);
        busRead(BASE_A + 32'h10, 32'h0000_0000, "isr_cleared_held_high");

        $display("[TB] GIE and IER gating");
        busWrite(BASE_A + 32'h08, 32'h0000_0000);
        padDrv = 32'h0; waitCycles(4);
        padDrv = 32'h0000_0001; waitCycles(5);
        checkOutput("irq_gie_off", {31'd0, irqA}, 32'h0);
        busRead(BASE_A + 32'h10, 32'h0000_0001, "isr_gie_off");
        busWrite(BASE_A + 32'h08, 32'h8000_0000);
        checkOutput("irq_gie_on", {31'd0, irqA}, 32'h1);
        busWrite(BASE_A + 32'h0C, 32'h0000_0000);
        waitCycles(1);
        checkOutput("irq_ier_off", {31'd0, irqA}, 32'h0);
        busRead(BASE_A + 32'h10, 32'h0000_0001, "isr_kept_ier_off");
        busWrite(BASE_A + 32'h0C, 32'hFFFF_FFFF);
        busWrite(BASE_A + 32'h10, 32'hFFFF_FFFF);
        padDrv = 32'h0; waitCycles(4);
        busRead(BASE_A + 32'h10, 32'h0000_0000, "isr_fall_ignored");

        $display("[TB] falling, both-edge and level modes");
        busWrite(BASE_A + 32'h34, 32'h0000_0050);
        busWrite(BASE_A + 32'h38, 32'h0000_0060);
        busRead(BASE_A + 32'h34, 32'h0000_0050, "imode0");
        padDrv = 32'h0000_0070; waitCycles(5);
        busRead(BASE_A + 32'h10, 32'h0000_0060, "isr_modes_rise");
        busWrite(BASE_A + 32'h10, 32'h0000_0060);
        busRead(BASE_A + 32'h10, 32'h0000_0040, "isr_level_reset");
        padDrv = 32'h0; waitCycles(5);
        busRead(BASE_A + 32'h10, 32'h0000_0070, "isr_modes_fall");
        busWrite(BASE_A + 32'h10, 32'hFFFF_FFFF);
        waitCycles(2);
        busRead(BASE_A + 32'h10, 32'h0000_0000, "isr_modes_clear");

        $display("[TB] 8-pin instance");
        busRead(BASE_B + 32'h20, 32'h0000_00FF, "b_dir_reset");
        busWrite(BASE_B + 32'h0C, 32'hFFFF_FFFF);
        busRead(BASE_B + 32'h0C, 32'h0000_00FF, "b_ier");
        busWrite(BASE_B + 32'h34, 32'hFFFF_FFFF);
        busRead(BASE_B + 32'h34, 32'h0000_00FF, "b_imode0");
        busWrite(BASE_B + 32'h24, 32'hFFFF_FFFF);
        busWrite(BASE_B + 32'h20, 32'h0000_0000);
        checkOutput("b_pad", {24'd0, padB}, 32'h0000_00FF);
        waitCycles(3);
        busRead(BASE_B + 32'h24, 32'h0000_00FF, "b_data");
        busWrite(BASE_B + 32'h20, 32'hFFFF_FFFF);
        busRead(BASE_B + 32'h20, 32'h0000_00FF, "b_dir");

        $display("[TB] reserved, read-only and out-of-window");
        busRead(BASE_A + 32'h14, 32'h0, "reserved_14");
        busRead(BASE_A + 32'h18, 32'h0, "unlisted_18");
        busWrite(BASE_A + 32'h3C, 32'hFFFF_FFFF);
        busRead(BASE_A + 32'h3C, 32'h0, "dben_absent");
        busWrite(BASE_A + 32'h00, 32'h0);
        busRead(BASE_A + 32'h00, 32'h0002_0000, "version_ro");
        busRead(BASE_A + 32'h40, 32'h0, "out_of_window_hi");
        busRead(BASE_A - 32'h4, 32'h0, "out_of_window_lo");

        waitCycles(5);
        checkCount++;
        if (expQ.size() == 0) passCount++;
        else $display("[TB] FAIL missing_ack: %0d pending, required 0", expQ.size());

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
